lc3_execute: RTL and testbench
==============================

Name:
lc3_execute

Overview:
- LC3 pipeline execute stage, directly downstream of decode.
- Consumes IR, E_Control, W_Control, Mem_Control and npc from decode.
- Produces sr1/sr2 addresses to the register file and resolves operands, with bypass from its own result and from memory.
- Registers the ALU result, effective address, destination and pass-through controls for the memory/writeback stages.

Parameters:
- NOP_IR, 16'h5020, IR value loaded at reset (AND R0,R0,#0).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
enable_execute  in  1  capture enable; low = hold all registers
IR  in  16  instruction from decode
npc_in  in  16  PC+1 from decode
E_Control  in  6  [5:4] alu_op, [3:2] pcsel1, [1] pcsel2, [0] op2sel
W_Control_in  in  2  writeback control, passed through
Mem_Control_in  in  1  memory control, passed through
VSR1  in  16  register-file read data for sr1
VSR2  in  16  register-file read data for sr2
bypass_alu  in  2  [0] operand1, [1] operand2 take this stage's registered aluout
bypass_mem  in  2  [0] operand1, [1] operand2 take Mem_Bypass_Val
Mem_Bypass_Val  in  16  value forwarded from memory stage
sr1  out  3  combinational: IR[8:6]
sr2  out  3  combinational: IR[11:9] if opcode ST/STR/STI (0011/0111/1011), else IR[2:0]
aluout  out  16  registered ALU result
pcout  out  16  registered effective address
W_Control_out  out  2  registered W_Control_in
Mem_Control_out  out  1  registered Mem_Control_in
dr  out  3  registered IR[11:9]
NZP  out  3  registered IR[11:9] when opcode BR (0000) or JMP (1100, forced 3'b111), else 0
M_Data  out  16  registered operand2 value (store data)
IR_exec  out  16  registered IR, for downstream decoding

Behaviour:
- Reset (rst high at posedge, overrides enable_execute):
  - IR_exec=NOP_IR.
  - aluout, pcout, M_Data = 0.
  - W_Control_out, Mem_Control_out, dr, NZP = 0.
- rst mid-operation discards the in-flight instruction; no partial update.
- All registered outputs update only on posedge with enable_execute=1; latency is one enabled cycle. enable_execute=0 holds every output, including across repeated stall cycles.
- Operand1 selection, priority order:
  - bypass_alu[0]: current aluout register;
  - else bypass_mem[0]: Mem_Bypass_Val;
  - else VSR1.
- Operand2 selection: same priority using bit [1] and VSR2. This value is also captured into M_Data.
- ALU second input: op2sel=1 selects operand2; op2sel=0 selects sext(IR[4:0]).
- alu_op: 00 ADD, 01 AND, 10 NOT operand1, 11 pass operand1.
- ADD wraps modulo 2^16; no flags are produced.
- Address path: pcout = A + B, modulo 2^16.
  - A by pcsel1: 00 sext(IR[10:0]), 01 sext(IR[8:0]), 10 sext(IR[5:0]), 11 zero.
  - B by pcsel2: 1 npc_in, 0 operand1.
- Simultaneous bypass_alu and bypass_mem on the same operand: ALU bypass wins.
- Self-bypass while stalled uses the held aluout.
- sr1/sr2 track IR combinationally, independent of enable_execute and rst.

Optional Feature:
- Macro: EXECUTE_BYPASS_EN.
- Defined: bypass muxes operate as described above.
- Undefined: bypass_alu, bypass_mem and Mem_Bypass_Val are ignored; operands come from VSR1/VSR2 only. Ports remain present.

Decomposition:
- Shared package lc3_pkg holds:
  - opcode constants (OP_BR, OP_ADD, OP_ST, OP_STR, OP_STI, OP_JMP, ...);
  - alu_op and pcsel enums;
  - E_Control bit-field positions;
  - NOP_IR constant.
- One sub-module, lc3_ext_unit: combinational ALU plus address adder, instantiated by the registered wrapper.

Test Plan:
- ADD R1,R2,R3 (IR=16'h1283), E_Control=6'b00_11_0_1, VSR1=5, VSR2=7, enable=1 -> next cycle aluout=12, dr=1, NZP=0.
- ADD R1,R2,#-1 (IR=16'h12BF), op2sel=0, VSR1=16'h0000 -> aluout=16'hFFFF (wrap).
- BRz #-2 (IR=16'h05FE), pcsel1=01, pcsel2=1, npc_in=16'h3005 -> pcout=16'h3003, NZP=3'b010.
- STR R4,R2,#3 (IR=16'h7883) -> sr2=4, M_Data=VSR2. Repeat with bypass_mem=2'b10, Mem_Bypass_Val=16'hBEEF -> M_Data=16'hBEEF.
- Back-to-back ADDs with bypass_alu=2'b01: first aluout=12, second adds #1 -> aluout=13. Both bypass bits set -> ALU value chosen.
- enable_execute=0 for 3 cycles with changing inputs -> outputs unchanged. rst asserted mid-stall -> IR_exec=16'h5020, all others 0.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared LC3 definitions: opcodes, execute-stage control encodings and the reset NOP.
package lc3_pkg;

   localparam logic [15:0] NOP_IR = 16'h5020;

   localparam logic [3:0] OP_BR   = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_LD   = 4'b0010;
   localparam logic [3:0] OP_ST   = 4'b0011;
   localparam logic [3:0] OP_JSR  = 4'b0100;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_LDR  = 4'b0110;
   localparam logic [3:0] OP_STR  = 4'b0111;
   localparam logic [3:0] OP_NOT  = 4'b1001;
   localparam logic [3:0] OP_LDI  = 4'b1010;
   localparam logic [3:0] OP_STI  = 4'b1011;
   localparam logic [3:0] OP_JMP  = 4'b1100;
   localparam logic [3:0] OP_LEA  = 4'b1110;
   localparam logic [3:0] OP_TRAP = 4'b1111;

   typedef enum logic [1:0] {
      ALU_ADD  = 2'b00,
      ALU_AND  = 2'b01,
      ALU_NOT  = 2'b10,
      ALU_PASS = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      PC_OFF11 = 2'b00,
      PC_OFF9  = 2'b01,
      PC_OFF6  = 2'b10,
      PC_ZERO  = 2'b11
   } pcsel1_e;

   // E_Control bit-field positions
   localparam int EC_ALU_HI    = 5;
   localparam int EC_ALU_LO    = 4;
   localparam int EC_PCSEL1_HI = 3;
   localparam int EC_PCSEL1_LO = 2;
   localparam int EC_PCSEL2    = 1;
   localparam int EC_OP2SEL    = 0;

   // Stores read their data register through the sr2 port.
   function automatic logic is_store(input logic [3:0] opcode);
      return (opcode == OP_ST) || (opcode == OP_STR) || (opcode == OP_STI);
   endfunction

endpackage

// File: rtl/lc3_execute_if.sv
// Decode/regfile/bypass-facing bundle of the LC3 execute stage.
// Valid/ready: none; the stage captures whenever enable_execute is high at posedge.
interface lc3_execute_if;
   logic        enable_execute;
   logic [15:0] IR;
   logic [15:0] npc_in;
   logic [5:0]  E_Control;
   logic [1:0]  W_Control_in;
   logic        Mem_Control_in;
   logic [15:0] VSR1;
   logic [15:0] VSR2;
   logic [1:0]  bypass_alu;
   logic [1:0]  bypass_mem;
   logic [15:0] Mem_Bypass_Val;
   logic [2:0]  sr1;
   logic [2:0]  sr2;
   logic [15:0] aluout;
   logic [15:0] pcout;
   logic [1:0]  W_Control_out;
   logic        Mem_Control_out;
   logic [2:0]  dr;
   logic [2:0]  NZP;
   logic [15:0] M_Data;
   logic [15:0] IR_exec;

   modport master (
      output enable_execute, IR, npc_in, E_Control, W_Control_in, Mem_Control_in,
             VSR1, VSR2, bypass_alu, bypass_mem, Mem_Bypass_Val,
      input  sr1, sr2, aluout, pcout, W_Control_out, Mem_Control_out, dr, NZP,
             M_Data, IR_exec
   );

   modport slave (
      input  enable_execute, IR, npc_in, E_Control, W_Control_in, Mem_Control_in,
             VSR1, VSR2, bypass_alu, bypass_mem, Mem_Bypass_Val,
      output sr1, sr2, aluout, pcout, W_Control_out, Mem_Control_out, dr, NZP,
             M_Data, IR_exec
   );
endinterface

// File: rtl/lc3_ext_unit.sv
// Combinational ALU and effective-address adder of the LC3 execute stage.
module lc3_ext_unit
   import lc3_pkg::*;
(
   input  logic [15:0] ir_i,
   input  logic [15:0] npc_i,
   input  logic [15:0] op1_i,
   input  logic [15:0] op2_i,
   input  logic [5:0]  e_control_i,
   output logic [15:0] alu_o,
   output logic [15:0] pc_o
);

   alu_op_e     alu_op;
   pcsel1_e     pcsel1;
   logic [15:0] alu_b;
   logic [15:0] addr_a;
   logic [15:0] addr_b;

   assign alu_op = alu_op_e'(e_control_i[EC_ALU_HI:EC_ALU_LO]);
   assign pcsel1 = pcsel1_e'(e_control_i[EC_PCSEL1_HI:EC_PCSEL1_LO]);
   assign alu_b  = e_control_i[EC_OP2SEL] ? op2_i : {{11{ir_i[4]}}, ir_i[4:0]};

   always_comb begin
      alu_o = 16'h0000;
      unique case (alu_op)
         ALU_ADD:  alu_o = op1_i + alu_b;
         ALU_AND:  alu_o = op1_i & alu_b;
         ALU_NOT:  alu_o = ~op1_i;
         ALU_PASS: alu_o = op1_i;
      endcase
   end

   always_comb begin
      addr_a = 16'h0000;
      unique case (pcsel1)
         PC_OFF11: addr_a = {{5{ir_i[10]}}, ir_i[10:0]};
         PC_OFF9:  addr_a = {{7{ir_i[8]}}, ir_i[8:0]};
         PC_OFF6:  addr_a = {{10{ir_i[5]}}, ir_i[5:0]};
         PC_ZERO:  addr_a = 16'h0000;
      endcase
   end

   assign addr_b = e_control_i[EC_PCSEL2] ? npc_i : op1_i;
   assign pc_o   = addr_a + addr_b;

endmodule

// File: rtl/lc3_execute.sv
// LC3 execute stage: operand resolution, ALU/address compute, registered hand-off to memory.
// Operand forwarding is compiled in only when EXECUTE_BYPASS_EN is defined.
module lc3_execute #(
   parameter logic [15:0] NOP_IR = lc3_pkg::NOP_IR
) (
   input  logic          clk,
   input  logic          rst,
   lc3_execute_if.slave  bus
);
   import lc3_pkg::*;

   logic [3:0]  opcode;
   logic [15:0] op1;
   logic [15:0] op2;
   logic [15:0] alu_d,  alu_q;
   logic [15:0] pc_d,   pc_q;
   logic [2:0]  nzp_d,  nzp_q;
   logic [15:0] ir_q;
   logic [1:0]  wctl_q;
   logic        mctl_q;
   logic [2:0]  dr_q;
   logic [15:0] mdata_q;

   assign opcode  = bus.IR[15:12];
   assign bus.sr1 = bus.IR[8:6];
   assign bus.sr2 = is_store(opcode) ? bus.IR[11:9] : bus.IR[2:0];

`ifdef EXECUTE_BYPASS_EN
   // ALU self-forwarding beats memory forwarding; a stalled stage forwards its held result.
   always_comb begin
      op1 = bus.VSR1;
      op2 = bus.VSR2;
      if (bus.bypass_alu[0])      op1 = alu_q;
      else if (bus.bypass_mem[0]) op1 = bus.Mem_Bypass_Val;
      if (bus.bypass_alu[1])      op2 = alu_q;
      else if (bus.bypass_mem[1]) op2 = bus.Mem_Bypass_Val;
   end
`else
   assign op1 = bus.VSR1;
   assign op2 = bus.VSR2;
`endif

   lc3_ext_unit u_ext (
      .ir_i        (bus.IR),
      .npc_i       (bus.npc_in),
      .op1_i       (op1),
      .op2_i       (op2),
      .e_control_i (bus.E_Control),
      .alu_o       (alu_d),
      .pc_o        (pc_d)
   );

   always_comb begin
      nzp_d = 3'b000;
      if (opcode == OP_BR)       nzp_d = bus.IR[11:9];
      else if (opcode == OP_JMP) nzp_d = 3'b111;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ir_q    <= NOP_IR;
         alu_q   <= 16'h0000;
         pc_q    <= 16'h0000;
         mdata_q <= 16'h0000;
         wctl_q  <= 2'b00;
         mctl_q  <= 1'b0;
         dr_q    <= 3'b000;
         nzp_q   <= 3'b000;
      end else if (bus.enable_execute) begin
         ir_q    <= bus.IR;
         alu_q   <= alu_d;
         pc_q    <= pc_d;
         mdata_q <= op2;
         wctl_q  <= bus.W_Control_in;
         mctl_q  <= bus.Mem_Control_in;
         dr_q    <= bus.IR[11:9];
         nzp_q   <= nzp_d;
      end
   end

   assign bus.IR_exec         = ir_q;
   assign bus.aluout          = alu_q;
   assign bus.pcout           = pc_q;
   assign bus.M_Data          = mdata_q;
   assign bus.W_Control_out   = wctl_q;
   assign bus.Mem_Control_out = mctl_q;
   assign bus.dr              = dr_q;
   assign bus.NZP             = nzp_q;

endmodule

// File: tb/tb_lc3_execute.sv
// Directed bench for lc3_execute: reference model checked every cycle plus literal spot checks.
module tb_lc3_execute;
  logic clk;
  logic rst;
  lc3_execute_if bus();

  int n_tests = 0;
  int n_fail  = 0;
  bit model_valid = 0;

  // reference state
  logic [15:0] m_ir, m_alu, m_pc, m_mdata;
  logic [1:0]  m_wctl;
  logic        m_mctl;
  logic [2:0]  m_dr, m_nzp;

  lc3_execute dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock ----------------
  initial clk = 0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sext(input logic [15:0] v, input int bits);
    int x;
    x = int'(v) & ((1 << bits) - 1);
    if (x >= (1 << (bits - 1))) x = x - (1 << bits);
    return 16'(x);
  endfunction

  // ---------------- model ----------------
  always @(posedge clk) begin
    logic [15:0] o1, o2, b, a, r, addr;
    int op;
    if (rst) begin
      model_valid <= 1;
      m_ir <= 16'h5020; m_alu <= 0; m_pc <= 0; m_mdata <= 0;
      m_wctl <= 0; m_mctl <= 0; m_dr <= 0; m_nzp <= 0;
    end else if (bus.enable_execute) begin
      o1 = bus.VSR1;
      o2 = bus.VSR2;
`ifdef EXECUTE_BYPASS_EN
      if (bus.bypass_alu[0]) o1 = m_alu; else if (bus.bypass_mem[0]) o1 = bus.Mem_Bypass_Val;
      if (bus.bypass_alu[1]) o2 = m_alu; else if (bus.bypass_mem[1]) o2 = bus.Mem_Bypass_Val;
`endif
      b = bus.E_Control[0] ? o2 : sext(bus.IR, 5);
      op = int'(bus.E_Control[5:4]);
      if (op == 0)      r = 16'((int'(o1) + int'(b)) % 65536);
      else if (op == 1) r = o1 & b;
      else if (op == 2) r = ~o1;
      else              r = o1;
      op = int'(bus.E_Control[3:2]);
      if (op == 0)      a = sext(bus.IR, 11);
      else if (op == 1) a = sext(bus.IR, 9);
      else if (op == 2) a = sext(bus.IR, 6);
      else              a = 0;
      addr = 16'((int'(a) + int'(bus.E_Control[1] ? bus.npc_in : o1)) % 65536);
      m_ir <= bus.IR; m_alu <= r; m_pc <= addr; m_mdata <= o2;
      m_wctl <= bus.W_Control_in; m_mctl <= bus.Mem_Control_in;
      m_dr <= bus.IR[11:9];
      if (bus.IR[15:12] == 4'd0)       m_nzp <= bus.IR[11:9];
      else if (bus.IR[15:12] == 4'd12) m_nzp <= 3'b111;
      else                             m_nzp <= 3'b000;
    end
  end

  // ---------------- compare every cycle ----------------
  always @(negedge clk) begin
    logic [3:0] opc;
    opc = bus.IR[15:12];
    chk("sr1", 16'(bus.sr1), 16'(bus.IR[8:6]));
    chk("sr2", 16'(bus.sr2), (opc == 4'd3 || opc == 4'd7 || opc == 4'd11) ?
                             16'(bus.IR[11:9]) : 16'(bus.IR[2:0]));
    if (model_valid) begin
      chk("IR_exec", bus.IR_exec, m_ir);
      chk("aluout", bus.aluout, m_alu);
      chk("pcout", bus.pcout, m_pc);
      chk("M_Data", bus.M_Data, m_mdata);
      chk("W_Control_out", 16'(bus.W_Control_out), 16'(m_wctl));
      chk("Mem_Control_out", 16'(bus.Mem_Control_out), 16'(m_mctl));
      chk("dr", 16'(bus.dr), 16'(m_dr));
      chk("NZP", 16'(bus.NZP), 16'(m_nzp));
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] ir, input logic [5:0] ec, input logic [15:0] v1,
                       input logic [15:0] v2, input logic [15:0] npc);
    bus.IR = ir; bus.E_Control = ec; bus.VSR1 = v1; bus.VSR2 = v2; bus.npc_in = npc;
    bus.W_Control_in = ir[1:0]; bus.Mem_Control_in = ir[5];
  endtask

  task automatic set_byp(input logic [1:0] ba, input logic [1:0] bm, input logic [15:0] mv);
    bus.bypass_alu = ba; bus.bypass_mem = bm; bus.Mem_Bypass_Val = mv;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1;
    bus.enable_execute = 1;
    drive(16'h0000, 6'b0, 16'h0, 16'h0, 16'h0);
    set_byp(2'b00, 2'b00, 16'h0);
    tick(); tick();
    chk("rst IR_exec", bus.IR_exec, 16'h5020);
    chk("rst aluout", bus.aluout, 16'h0000);
    chk("rst dr", 16'(bus.dr), 16'h0);
    rst = 0;

    // ADD R1,R2,R3
    drive(16'h1283, 6'b00_11_0_1, 16'd5, 16'd7, 16'h3000);
    #1;
    chk("add sr1", 16'(bus.sr1), 16'd2);
    chk("add sr2", 16'(bus.sr2), 16'd3);
    tick();
    chk("add aluout", bus.aluout, 16'd12);
    chk("add dr", 16'(bus.dr), 16'd1);
    chk("add NZP", 16'(bus.NZP), 16'd0);

    // ADD R1,R2,#-1 wraps
    drive(16'h12BF, 6'b00_11_0_0, 16'h0000, 16'h1111, 16'h3001);
    tick();
    chk("add imm wrap", bus.aluout, 16'hFFFF);

    // BRz #-2
    drive(16'h05FE, 6'b00_01_1_0, 16'h0000, 16'h0000, 16'h3005);
    tick();
    chk("br pcout", bus.pcout, 16'h3003);
    chk("br NZP", 16'(bus.NZP), 16'b010);

    // STR R4,R2,#3
    drive(16'h7883, 6'b00_10_0_0, 16'h4000, 16'h1234, 16'h3006);
    #1;
    chk("str sr2", 16'(bus.sr2), 16'd4);
    tick();
    chk("str M_Data", bus.M_Data, 16'h1234);
    chk("str pcout", bus.pcout, 16'h4003);
    set_byp(2'b00, 2'b10, 16'hBEEF);
    tick();
`ifdef EXECUTE_BYPASS_EN
    chk("str mem bypass", bus.M_Data, 16'hBEEF);
`else
    chk("str no bypass", bus.M_Data, 16'h1234);
`endif
    set_byp(2'b00, 2'b00, 16'h0);

    // AND and NOT
    drive(16'h5642, 6'b01_11_0_1, 16'hF0F0, 16'hFF00, 16'h3007);
    tick();
    chk("and", bus.aluout, 16'hF000);
    drive(16'h967F, 6'b10_11_0_0, 16'h00FF, 16'h0000, 16'h3008);
    tick();
    chk("not", bus.aluout, 16'hFF00);

    // JMP R2
    drive(16'hC080, 6'b11_11_0_0, 16'h4321, 16'h0000, 16'h3009);
    tick();
    chk("jmp pcout", bus.pcout, 16'h4321);
    chk("jmp NZP", 16'(bus.NZP), 16'b111);

    // back-to-back with ALU self-bypass
    drive(16'h1283, 6'b00_11_0_1, 16'd5, 16'd7, 16'h300A);
    tick();
    chk("b2b first", bus.aluout, 16'd12);
    drive(16'h1261, 6'b00_11_0_0, 16'd100, 16'd0, 16'h300B);
    set_byp(2'b01, 2'b00, 16'h0500);
    tick();
`ifdef EXECUTE_BYPASS_EN
    chk("b2b alu bypass", bus.aluout, 16'd13);
`else
    chk("b2b no bypass", bus.aluout, 16'd101);
`endif
    set_byp(2'b01, 2'b01, 16'h0500);
    tick();
`ifdef EXECUTE_BYPASS_EN
    chk("both bypass alu wins", bus.aluout, 16'd14);
`else
    chk("both bypass ignored", bus.aluout, 16'd101);
`endif
    set_byp(2'b00, 2'b00, 16'h0);

    // stall with changing inputs
    drive(16'h1283, 6'b00_11_0_1, 16'd5, 16'd7, 16'h300C);
    tick();
    chk("pre-stall", bus.aluout, 16'd12);
    bus.enable_execute = 0;
    for (int i = 0; i < 3; i++) begin
      drive(16'h05FE + 16'(i), 6'b00_01_1_1, 16'(i * 77), 16'(i * 91), 16'h5000);
      tick();
    end
    chk("stall aluout", bus.aluout, 16'd12);
    chk("stall dr", 16'(bus.dr), 16'd1);
    chk("stall IR_exec", bus.IR_exec, 16'h1283);

    // release with self-bypass of the held result
    bus.enable_execute = 1;
    drive(16'h1261, 6'b00_11_0_0, 16'd200, 16'd0, 16'h300D);
    set_byp(2'b01, 2'b00, 16'h0);
    tick();
`ifdef EXECUTE_BYPASS_EN
    chk("post-stall bypass", bus.aluout, 16'd13);
`else
    chk("post-stall no bypass", bus.aluout, 16'd201);
`endif
    set_byp(2'b00, 2'b00, 16'h0);

    // reset in the middle of a stall
    drive(16'h7883, 6'b00_10_0_0, 16'h4000, 16'h1234, 16'h300E);
    tick();
    bus.enable_execute = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("midrst IR_exec", bus.IR_exec, 16'h5020);
    chk("midrst pcout", bus.pcout, 16'h0000);
    chk("midrst M_Data", bus.M_Data, 16'h0000);
    chk("midrst W_Control_out", 16'(bus.W_Control_out), 16'h0);
    tick();
    bus.enable_execute = 1;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
